// File: rtl/alu_regfile_if.sv
// alu_regfile_if: bundles the register-file write/read ports and ALU controls/results.
// Modports: master drives writes, read addresses and ALU controls; slave is the regfile/ALU side.
interface alu_regfile_if #(
    parameter int WIDTH_WORD = 8,
    parameter int WIDTH_SEG  = 4
);
    logic                  write0;
    logic [WIDTH_SEG-1:0]  dstreg0;
    logic [WIDTH_WORD-1:0] dstval0;
    logic                  write1;
    logic [WIDTH_SEG-1:0]  dstreg1;
    logic [WIDTH_WORD-1:0] dstval1;
    logic [WIDTH_SEG-1:0]  argreg0;
    logic [WIDTH_WORD-1:0] argval0;
    logic [WIDTH_SEG-1:0]  argreg1;
    logic [WIDTH_WORD-1:0] argval1;
    logic                  alu_en;
    logic [2:0]            alu_fn;
    logic [WIDTH_WORD-1:0] dstval;
    logic                  carry;

    modport master (
        output write0, dstreg0, dstval0,
        output write1, dstreg1, dstval1,
        output argreg0, argreg1,
        output alu_en, alu_fn,
        input  argval0, argval1,
        input  dstval, carry
    );

    modport slave (
        input  write0, dstreg0, dstval0,
        input  write1, dstreg1, dstval1,
        input  argreg0, argreg1,
        input  alu_en, alu_fn,
        output argval0, argval1,
        output dstval, carry
    );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 2**WIDTH_SEG x WIDTH_WORD register file (2 write, 2 read ports) feeding a combinational ALU.
// Ports: clk, rst (sync, active-high); bus (alu_regfile_if.slave) carries writes, reads, ALU controls and results.
module alu_regfile #(
    parameter int WIDTH_WORD = 8,
    parameter int WIDTH_SEG  = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_regfile_if.slave bus
);
    localparam int DEPTH = 2 ** WIDTH_SEG;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_OR  = 3'b010,
        FN_NOT = 3'b011,
        FN_MV  = 3'b100,
        FN_AND = 3'b101,
        FN_XOR = 3'b110,
        FN_B   = 3'b111
    } alu_fn_e;

    logic [WIDTH_WORD-1:0] regs [DEPTH];

    // Port 1 is written last so it wins when both ports target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (bus.write0) begin
                regs[bus.dstreg0] <= bus.dstval0;
            end
            if (bus.write1) begin
                regs[bus.dstreg1] <= bus.dstval1;
            end
        end
    end

    // Reads are not bypassed: a same-cycle write shows up after the edge.
    logic [WIDTH_WORD-1:0] op_a;
    logic [WIDTH_WORD-1:0] op_b;

    assign op_a        = regs[bus.argreg0];
    assign op_b        = regs[bus.argreg1];
    assign bus.argval0 = op_a;
    assign bus.argval1 = op_b;

    // Extended by one bit so the top bit is carry (add) or borrow (sub).
    logic [WIDTH_WORD:0]   sum_ext;
    logic [WIDTH_WORD:0]   diff_ext;
    logic [WIDTH_WORD-1:0] result;
    logic                  result_c;

    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        result   = '0;
        result_c = 1'b0;
        if (bus.alu_en) begin
            unique case (alu_fn_e'(bus.alu_fn))
                FN_ADD: begin
                    result   = sum_ext[WIDTH_WORD-1:0];
                    result_c = sum_ext[WIDTH_WORD];
                end
                FN_SUB: begin
                    result   = diff_ext[WIDTH_WORD-1:0];
                    result_c = diff_ext[WIDTH_WORD];
                end
                FN_OR:  result = op_a | op_b;
                FN_NOT: result = ~op_a;
                FN_MV:  result = op_a;
                FN_AND: result = op_a & op_b;
                FN_XOR: result = op_a ^ op_b;
                FN_B:   result = op_b;
                default: begin
                    result   = '0;
                    result_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.dstval = result;
    assign bus.carry  = result_c;
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed checks of reset, writes, ALU functions and edge cases.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_alu_regfile;
    localparam int WW = 8;
    localparam int WS = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_regfile_if #(.WIDTH_WORD(WW), .WIDTH_SEG(WS)) bus ();

    alu_regfile #(.WIDTH_WORD(WW), .WIDTH_SEG(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write0  = 1'b0;
        bus.dstreg0 = '0;
        bus.dstval0 = '0;
        bus.write1  = 1'b0;
        bus.dstreg1 = '0;
        bus.dstval1 = '0;
        bus.alu_en  = 1'b0;
        bus.alu_fn  = 3'b000;
    endtask

    task automatic wr(input logic w0, input logic [WS-1:0] d0,
                      input logic [WW-1:0] v0, input logic w1,
                      input logic [WS-1:0] d1, input logic [WW-1:0] v1);
        bus.write0  = w0;
        bus.dstreg0 = d0;
        bus.dstval0 = v0;
        bus.write1  = w1;
        bus.dstreg1 = d1;
        bus.dstval1 = v1;
        tick();
        bus.write0 = 1'b0;
        bus.write1 = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.argreg0 = '0;
        bus.argreg1 = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.argreg0 = WS'(i);
            bus.argreg1 = WS'(15 - i);
            #1;
            checks++;
            if (bus.argval0 !== 8'h00) begin
                errors++;
                $display("FAIL reset_rd0[%0d] got=%h exp=00", i, bus.argval0);
            end
            checks++;
            if (bus.argval1 !== 8'h00) begin
                errors++;
                $display("FAIL reset_rd1[%0d] got=%h exp=00", 15 - i, bus.argval1);
            end
        end
        bus.alu_en = 1'b1;
        bus.alu_fn = 3'b011;
        #1;
        checks++;
        if (bus.dstval !== 8'hFF) begin
            errors++;
            $display("FAIL reset_not got=%h exp=ff", bus.dstval);
        end
        idle();
    endtask

    task automatic test_add_writeback();
        logic [WW-1:0] res;
        wr(1'b1, 4'd1, 8'd8, 1'b0, 4'd0, 8'd0);
        wr(1'b1, 4'd3, 8'd5, 1'b0, 4'd0, 8'd0);
        bus.argreg0 = 4'd3;
        bus.argreg1 = 4'd1;
        bus.alu_en  = 1'b1;
        bus.alu_fn  = 3'b000;
        #1;
        checks++;
        if (bus.dstval !== 8'd13 || bus.carry !== 1'b0) begin
            errors++;
            $display("FAIL add_8_5 got=%h/%b exp=0d/0", bus.dstval, bus.carry);
        end
        res = bus.dstval;
        wr(1'b1, 4'd2, res, 1'b0, 4'd0, 8'd0);
        bus.argreg0 = 4'd2;
        #1;
        checks++;
        if (bus.argval0 !== 8'd13) begin
            errors++;
            $display("FAIL wb_r2 got=%h exp=0d", bus.argval0);
        end
        idle();
    endtask

    task automatic test_carry_borrow();
        wr(1'b1, 4'd6, 8'hFF, 1'b1, 4'd7, 8'h02);
        wr(1'b1, 4'd8, 8'h02, 1'b1, 4'd9, 8'h05);
        bus.argreg0 = 4'd6;
        bus.argreg1 = 4'd7;
        bus.alu_en  = 1'b1;
        bus.alu_fn  = 3'b000;
        #1;
        checks++;
        if (bus.dstval !== 8'h01 || bus.carry !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got=%h/%b exp=01/1", bus.dstval, bus.carry);
        end
        bus.argreg0 = 4'd8;
        bus.argreg1 = 4'd9;
        bus.alu_fn  = 3'b001;
        #1;
        checks++;
        if (bus.dstval !== 8'hFD || bus.carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow got=%h/%b exp=fd/1", bus.dstval, bus.carry);
        end
        bus.argreg0 = 4'd9;
        bus.argreg1 = 4'd8;
        #1;
        checks++;
        if (bus.dstval !== 8'h03 || bus.carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_noborrow got=%h/%b exp=03/0", bus.dstval, bus.carry);
        end
        idle();
    endtask

    task automatic test_all_fn();
        logic [WW-1:0] exp_v [8];
        logic          exp_c [8];
        exp_v = '{8'h1F, 8'h6B, 8'hDF, 8'h3A, 8'hC5, 8'h40, 8'h9F, 8'h5A};
        exp_c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        wr(1'b1, 4'd10, 8'hC5, 1'b1, 4'd11, 8'h5A);
        bus.argreg0 = 4'd10;
        bus.argreg1 = 4'd11;
        bus.alu_en  = 1'b1;
        for (int f = 0; f < 8; f++) begin
            bus.alu_fn = 3'(f);
            #1;
            checks++;
            if (bus.dstval !== exp_v[f] || bus.carry !== exp_c[f]) begin
                errors++;
                $display("FAIL fn%0d got=%h/%b exp=%h/%b",
                         f, bus.dstval, bus.carry, exp_v[f], exp_c[f]);
            end
        end
        bus.alu_en = 1'b0;
        bus.alu_fn = 3'b000;
        #1;
        checks++;
        if (bus.dstval !== 8'h00 || bus.carry !== 1'b0) begin
            errors++;
            $display("FAIL alu_off got=%h/%b exp=00/0", bus.dstval, bus.carry);
        end
        idle();
    endtask

    task automatic test_dual_write();
        wr(1'b1, 4'd15, 8'h77, 1'b0, 4'd0, 8'd0);
        wr(1'b1, 4'd14, 8'h0C, 1'b1, 4'd15, 8'h00);
        bus.argreg0 = 4'd14;
        bus.argreg1 = 4'd15;
        #1;
        checks++;
        if ({bus.argval1, bus.argval0} !== 16'h000C) begin
            errors++;
            $display("FAIL pc_pair got=%h exp=000c", {bus.argval1, bus.argval0});
        end
        wr(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22);
        bus.argreg0 = 4'd5;
        #1;
        checks++;
        if (bus.argval0 !== 8'h22) begin
            errors++;
            $display("FAIL same_addr got=%h exp=22", bus.argval0);
        end
        idle();
    endtask

    task automatic test_no_bypass_and_reset();
        bus.argreg0 = 4'd4;
        bus.argreg1 = 4'd1;
        bus.write0  = 1'b1;
        bus.dstreg0 = 4'd4;
        bus.dstval0 = 8'hAA;
        #1;
        checks++;
        if (bus.argval0 !== 8'h00) begin
            errors++;
            $display("FAIL no_bypass got=%h exp=00", bus.argval0);
        end
        tick();
        bus.write0 = 1'b0;
        checks++;
        if (bus.argval0 !== 8'hAA) begin
            errors++;
            $display("FAIL after_edge got=%h exp=aa", bus.argval0);
        end
        rst = 1'b1;
        wr(1'b1, 4'd4, 8'h55, 1'b1, 4'd1, 8'h66);
        rst = 1'b0;
        bus.alu_en = 1'b1;
        bus.alu_fn = 3'b000;
        #1;
        checks++;
        if (bus.argval0 !== 8'h00 || bus.argval1 !== 8'h00) begin
            errors++;
            $display("FAIL rst_over_wr got=%h/%h exp=00/00", bus.argval0, bus.argval1);
        end
        checks++;
        if (bus.dstval !== 8'h00 || bus.carry !== 1'b0) begin
            errors++;
            $display("FAIL rst_alu got=%h/%b exp=00/0", bus.dstval, bus.carry);
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.argreg0 = '0;
        bus.argreg1 = '0;
        idle();
        tick();
        test_reset();
        test_add_writeback();
        test_carry_borrow();
        test_all_fn();
        test_dual_write();
        test_no_bypass_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
